// File: rtl/three_shuffler_ctrl_if.sv
// Flag/select bundle between the upstream 3-parallel FFT stage, three_shuffler_ctrl
// and the shuffler datapath. The controller connects through the slave modport.
interface three_shuffler_ctrl_if;
  logic        in_valid;
  logic        in_sof;
  logic        in_ready;
  logic [7:0]  sel_bus;
  logic        busy;
  logic        out_valid;
  logic        out_sof;
  logic        underrun;
  logic [15:0] frame_cnt;

  modport master (
    output in_valid, in_sof,
    input  in_ready, sel_bus, busy, out_valid, out_sof, underrun, frame_cnt
  );

  modport slave (
    input  in_valid, in_sof,
    output in_ready, sel_bus, busy, out_valid, out_sof, underrun, frame_cnt
  );
endinterface

// File: rtl/three_shuffler_ctrl.sv
// Sequencing controller for the 3-parallel shuffler: frame counter, select generation,
// valid/sof re-timing, underrun and drain. Define SHUF_FRAME_CNT_EN to enable frame_cnt.
module three_shuffler_ctrl #(
  parameter int FRAME_LEN = 90,
  parameter int LAT       = 91,
  parameter int SEL_DELAY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  three_shuffler_ctrl_if.slave bus
);
  localparam int              CW         = $clog2(FRAME_LEN);
  localparam int              SW         = (SEL_DELAY + 1) * 8;
  localparam logic [CW-1:0]   LAST       = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]   HALF       = CW'(FRAME_LEN / 2);
  // The frame-end RUN cycle is the first drain cycle, so DRAIN itself lasts LAT-1 cycles.
  localparam logic [7:0]      DRAIN_LOAD = (LAT > 1) ? 8'(LAT - 2) : 8'd0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   c_q, c_d;
  logic [1:0]      p_q, p_d;
  logic [7:0]      drain_q, drain_d;
  logic [LAT-1:0]  vld_q, vld_d;
  logic [LAT-1:0]  sof_q, sof_d;
  logic [SW-1:0]   sel_pipe_q, sel_pipe_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            underrun_q, underrun_d;

  logic            frame_end, start, cont, acc, h;
  logic [CW-1:0]   k;
  logic [1:0]      kp;
  logic [7:0]      pat;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    c_d        = c_q;
    p_d        = p_q;
    drain_d    = drain_q;
    pat        = '0;

    // In RUN, c_q is the index of the last accepted word; c_q==LAST means the frame is complete.
    frame_end  = (state_q == RUN) && (c_q == LAST);
    start      = bus.in_valid && bus.in_sof && ((state_q != RUN) || frame_end);
    cont       = (state_q == RUN) && !frame_end;
    acc        = start || cont;
    k          = start ? '0 : c_q + CW'(1);
    kp         = start ? 2'd0 : ((p_q == 2'd2) ? 2'd0 : p_q + 2'd1);
    h          = (k >= HALF);

    if (acc) begin
      pat = {k == LAST, (kp == 2'd2) | h, (kp == 2'd1) & ~h, (kp == 2'd0) & h,
             h, kp == 2'd2, kp == 2'd1, kp == 2'd0};
    end

    if (acc) begin
      state_d = RUN;
      c_d     = k;
      p_d     = kp;
    end else begin
      case (state_q)
        RUN: begin
          if (LAT > 1) begin
            state_d = DRAIN;
            drain_d = DRAIN_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        DRAIN: begin
          if (drain_q == 8'd0) state_d = IDLE;
          else                 drain_d = drain_q - 8'd1;
        end
        default: ;
      endcase
    end

    vld_d      = LAT'({vld_q, acc});
    sof_d      = LAT'({sof_q, start});
    sel_pipe_d = SW'({sel_pipe_q, pat});
    underrun_d = underrun_q | (cont & ~bus.in_valid);
    in_ready_d = (state_d != RUN) || (c_d == LAST);
    busy_d     = (state_d != IDLE) || (|vld_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so flop order never matters.
    if (!rst_n) begin
      state_q    <= IDLE;
      c_q        <= '0;
      p_q        <= 2'd0;
      drain_q    <= 8'd0;
      // NOTE: the flag delay lines are plain flop chains and are reset so an aborted frame
      // leaves no pending out_valid/out_sof behind.
      vld_q      <= '0;
      sof_q      <= '0;
      sel_pipe_q <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      p_q        <= p_d;
      drain_q    <= drain_d;
      vld_q      <= vld_d;
      sof_q      <= sof_d;
      sel_pipe_q <= sel_pipe_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef SHUF_FRAME_CNT_EN
  logic [LAT-1:0] last_q, last_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;

  always_comb begin
    last_d      = LAT'({last_q, pat[7]});
    frame_cnt_d = frame_cnt_q + 16'(vld_q[LAT-1] & last_q[LAT-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q      <= '0;
      frame_cnt_q <= 16'd0;
    end else begin
      last_q      <= last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
`else
  assign bus.frame_cnt = 16'd0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.sel_bus   = sel_pipe_q[SW-1 -: 8];
  assign bus.busy      = busy_q;
  assign bus.out_valid = vld_q[LAT-1];
  assign bus.out_sof   = sof_q[LAT-1];
  assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_three_shuffler_ctrl.sv
// Directed bench for three_shuffler_ctrl: default build (dut0) and SEL_DELAY=2 (dut2)
// share one stimulus stream. frame_cnt expectations follow SHUF_FRAME_CNT_EN.
module tb_three_shuffler_ctrl;
`ifdef SHUF_FRAME_CNT_EN
  localparam int FC_ON = 1;
`else
  localparam int FC_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  three_shuffler_ctrl_if bus0 ();
  three_shuffler_ctrl_if bus2 ();

  three_shuffler_ctrl dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  three_shuffler_ctrl #(.SEL_DELAY(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;

  // Select pattern for word index k in a 90-word frame, written straight from the formulas.
  function automatic logic [7:0] exp_sel(input int k);
    int p;
    bit h;
    p = k % 3;
    h = (k >= 45);
    return {k == 89, (p == 2) || h, (p == 1) && !h, (p == 0) && h, h, p == 2, p == 1, p == 0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s);
    bus0.in_valid = v;
    bus0.in_sof   = s;
    bus2.in_valid = v;
    bus2.in_sof   = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1);
    repeat (3) tick();
    n_checks++; if (bus0.sel_bus !== 8'h00) begin n_fail++; $display("FAIL rst_sel: got %h want 00", bus0.sel_bus); end
    n_checks++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus0.out_valid); end
    n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bus0.in_ready); end
    n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus0.busy); end
    n_checks++; if (bus0.underrun !== 1'b0) begin n_fail++; $display("FAIL rst_underrun: got %b want 0", bus0.underrun); end
    n_checks++; if (bus2.frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_frame_cnt: got %0d want 0", bus2.frame_cnt); end
    rst_n = 1'b1;
    tick();
    drive(1'b0, 1'b0);
    n_checks++; if (bus0.sel_bus !== 8'h01) begin n_fail++; $display("FAIL rst_first_sof_sel: got %h want 01", bus0.sel_bus); end
    n_checks++; if (bus0.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_first_sof_ready: got %b want 0", bus0.in_ready); end
    n_checks++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL rst_first_sof_busy: got %b want 1", bus0.busy); end
  endtask

  task automatic test_single_frame();
    int ov_cnt = 0, first_ov = -1, last_ov = -1, sof_cnt = 0, sof_pos = -1;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      int j;
      drive(i < 90, i == 0);
      tick();
      j = i + 1;
      if (j <= 91) begin
        exp = (j <= 90) ? exp_sel(j - 1) : 8'h00;
        n_checks++; if (bus0.sel_bus !== exp) begin n_fail++; $display("FAIL single_sel c=%0d: got %h want %h", j - 1, bus0.sel_bus, exp); end
      end
      if (j == 1)  begin n_checks++; if (bus0.sel_bus !== 8'h01) begin n_fail++; $display("FAIL single_sel_c0: got %h want 01", bus0.sel_bus); end end
      if (j == 2)  begin n_checks++; if (bus0.sel_bus !== 8'h22) begin n_fail++; $display("FAIL single_sel_c1: got %h want 22", bus0.sel_bus); end end
      if (j == 3)  begin n_checks++; if (bus0.sel_bus !== 8'h44) begin n_fail++; $display("FAIL single_sel_c2: got %h want 44", bus0.sel_bus); end end
      if (j == 45) begin n_checks++; if (bus0.sel_bus !== 8'h44) begin n_fail++; $display("FAIL single_sel_c44: got %h want 44", bus0.sel_bus); end end
      if (j == 46) begin n_checks++; if (bus0.sel_bus !== 8'h59) begin n_fail++; $display("FAIL single_sel_c45: got %h want 59", bus0.sel_bus); end end
      if (j == 90) begin
        n_checks++; if (bus0.sel_bus !== 8'hCC) begin n_fail++; $display("FAIL single_sel_c89: got %h want cc", bus0.sel_bus); end
        n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_at_end: got %b want 1", bus0.in_ready); end
      end
      if (j == 50) begin n_checks++; if (bus0.in_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_mid: got %b want 0", bus0.in_ready); end end
      if (j == 180) begin n_checks++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_last_ov: got %b want 1", bus0.busy); end end
      if (j == 181) begin n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b want 0", bus0.busy); end end
      if (bus0.out_valid) begin ov_cnt++; if (first_ov < 0) first_ov = j; last_ov = j; end
      if (bus0.out_sof) begin sof_cnt++; sof_pos = j; end
    end
    n_checks++; if (ov_cnt !== 90) begin n_fail++; $display("FAIL single_ov_count: got %0d want 90", ov_cnt); end
    n_checks++; if (first_ov !== 91) begin n_fail++; $display("FAIL single_ov_first: got %0d want 91", first_ov); end
    n_checks++; if (last_ov !== 180) begin n_fail++; $display("FAIL single_ov_last: got %0d want 180", last_ov); end
    n_checks++; if (sof_cnt !== 1 || sof_pos !== 91) begin n_fail++; $display("FAIL single_out_sof: got %0d at %0d want 1 at 91", sof_cnt, sof_pos); end
  endtask

  task automatic test_back_to_back();
    int ov_cnt = 0, first_ov = -1, last_ov = -1, sof_cnt = 0, busy_low = 0;
    int sof_pos[2] = '{-1, -1};
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int j;
      drive(i < 180, (i == 0) || (i == 90));
      tick();
      j = i + 1;
      if (j == 90) begin n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_c89: got %b want 1", bus0.in_ready); end end
      if (j == 91) begin
        n_checks++; if (bus0.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_no_drain: in_ready got %b want 0", bus0.in_ready); end
        n_checks++; if (bus0.sel_bus !== 8'h01) begin n_fail++; $display("FAIL b2b_wrap_sel: got %h want 01", bus0.sel_bus); end
      end
      if (j == 92) begin n_checks++; if (bus0.sel_bus !== 8'h22) begin n_fail++; $display("FAIL b2b_sel_c1: got %h want 22", bus0.sel_bus); end end
      if (j <= 270 && !bus0.busy) busy_low++;
      if (bus0.out_valid) begin ov_cnt++; if (first_ov < 0) first_ov = j; last_ov = j; end
      if (bus0.out_sof) begin if (sof_cnt < 2) sof_pos[sof_cnt] = j; sof_cnt++; end
    end
    n_checks++; if (ov_cnt !== 180) begin n_fail++; $display("FAIL b2b_ov_count: got %0d want 180", ov_cnt); end
    n_checks++; if (first_ov !== 91 || last_ov !== 270) begin n_fail++; $display("FAIL b2b_ov_span: got %0d..%0d want 91..270", first_ov, last_ov); end
    n_checks++; if (sof_cnt !== 2 || sof_pos[0] !== 91 || sof_pos[1] !== 181) begin n_fail++; $display("FAIL b2b_out_sof: got %0d at %0d,%0d want 2 at 91,181", sof_cnt, sof_pos[0], sof_pos[1]); end
    n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL b2b_busy_gap: got %0d idle cycles want 0", busy_low); end
  endtask

  task automatic test_underrun();
    int ov_cnt = 0;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      int j;
      drive((i < 90) && (i != 20), i == 0);
      tick();
      j = i + 1;
      if (j == 20) begin n_checks++; if (bus0.underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_early: got %b want 0", bus0.underrun); end end
      if (j == 21) begin n_checks++; if (bus0.underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_set: got %b want 1", bus0.underrun); end end
      if (j == 22) begin n_checks++; if (bus0.sel_bus !== 8'h01) begin n_fail++; $display("FAIL underrun_sel_c21: got %h want 01", bus0.sel_bus); end end
      if (bus0.out_valid) ov_cnt++;
    end
    n_checks++; if (bus0.underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b want 1", bus0.underrun); end
    n_checks++; if (ov_cnt !== 90) begin n_fail++; $display("FAIL underrun_ov_count: got %0d want 90", ov_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int ov_cnt = 0;
    do_reset();
    for (int i = 0; i <= 40; i++) begin
      drive(1'b1, i == 0);
      if (i == 40) begin
        n_checks++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", bus0.busy); end
        rst_n = 1'b0;
      end
      tick();
    end
    n_checks++; if (bus0.sel_bus !== 8'h00) begin n_fail++; $display("FAIL midrst_sel: got %h want 00", bus0.sel_bus); end
    n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus0.busy); end
    n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", bus0.in_ready); end
    rst_n = 1'b1;
    drive(1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus0.out_valid || bus2.out_valid) ov_cnt++;
    end
    n_checks++; if (ov_cnt !== 0) begin n_fail++; $display("FAIL midrst_stale_ov: got %0d want 0", ov_cnt); end
  endtask

  task automatic test_sel_delay();
    int ov_cnt = 0, sof_cnt = 0;
    logic [7:0] exp0, exp2;
    do_reset();
    for (int i = 0; i < 420; i++) begin
      int j;
      drive(i < 270, (i % 90) == 0);
      tick();
      j = i + 1;
      if (j <= 275) begin
        exp0 = (j - 1 < 270) ? exp_sel((j - 1) % 90) : 8'h00;
        exp2 = (j >= 3 && j - 3 < 270) ? exp_sel((j - 3) % 90) : 8'h00;
        n_checks++; if (bus0.sel_bus !== exp0) begin n_fail++; $display("FAIL dly0_sel cyc=%0d: got %h want %h", j, bus0.sel_bus, exp0); end
        n_checks++; if (bus2.sel_bus !== exp2) begin n_fail++; $display("FAIL dly2_sel cyc=%0d: got %h want %h", j, bus2.sel_bus, exp2); end
      end
      if (j == 360) begin n_checks++; if (bus2.frame_cnt !== 16'(2 * FC_ON)) begin n_fail++; $display("FAIL dly2_frame_cnt_pre: got %0d want %0d", bus2.frame_cnt, 2 * FC_ON); end end
      if (bus2.out_valid) ov_cnt++;
      if (bus2.out_sof) sof_cnt++;
    end
    n_checks++; if (ov_cnt !== 270) begin n_fail++; $display("FAIL dly2_ov_count: got %0d want 270", ov_cnt); end
    n_checks++; if (sof_cnt !== 3) begin n_fail++; $display("FAIL dly2_sof_count: got %0d want 3", sof_cnt); end
    n_checks++; if (bus2.frame_cnt !== 16'(3 * FC_ON)) begin n_fail++; $display("FAIL dly2_frame_cnt: got %0d want %0d", bus2.frame_cnt, 3 * FC_ON); end
    n_checks++; if (bus0.frame_cnt !== 16'(3 * FC_ON)) begin n_fail++; $display("FAIL dly0_frame_cnt: got %0d want %0d", bus0.frame_cnt, 3 * FC_ON); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
    test_sel_delay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
